// File: rtl/ipsum_fifo_pkg.sv
// Shared types for the psum FIFOs: entry/word widths and the push/pop mode encoding.
package ipsum_fifo_pkg;

  localparam int unsigned PSUM_W = 16;
  localparam int unsigned GLB_W  = 32;

  typedef logic [PSUM_W-1:0] psum_t;
  typedef logic [GLB_W-1:0]  glb_word_t;

  typedef enum logic {
    PUSH16 = 1'b0,
    PUSH32 = 1'b1
  } push_mode_e;

endpackage

// File: rtl/ipsum_fifo_if.sv
// Push/pop bus of the input-psum FIFO; IPSUM_FIFO_ERR_EN adds the sticky error flags.
interface ipsum_fifo_if
  import ipsum_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            push_en;
  logic            push_mod;
  glb_word_t       push_data;
  logic            full;
  logic            ready32;
  logic            pop_en;
  psum_t           pop_data;
  logic            empty;
  logic [CW-1:0]   count;
`ifdef IPSUM_FIFO_ERR_EN
  logic            ovf_err;
  logic            udf_err;
`endif

  modport master (
    output push_en, push_mod, push_data, pop_en,
    input  full, ready32, pop_data, empty, count
`ifdef IPSUM_FIFO_ERR_EN
    , input ovf_err, udf_err
`endif
  );

  modport slave (
    input  push_en, push_mod, push_data, pop_en,
    output full, ready32, pop_data, empty, count
`ifdef IPSUM_FIFO_ERR_EN
    , output ovf_err, udf_err
`endif
  );

endinterface

// File: rtl/ipsum_fifo_mem.sv
// DEPTH x PSUM_W register file: two write ports (second only for 32-bit pushes), one async read.
module ipsum_fifo_mem
  import ipsum_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] addr0_i,
  input  psum_t                    data0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] addr1_i,
  input  psum_t                    data1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output psum_t                    rdata_o
);

  psum_t mem_q [DEPTH];

  // The two write addresses are always consecutive, so they never collide.
  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[addr0_i] <= data0_i;
    if (we1_i) mem_q[addr1_i] <= data1_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ipsum_fifo.sv
// Input-psum FWFT FIFO: 16- or 32-bit (two-entry) pushes, one 16-bit psum per pop.
// Optional macro IPSUM_FIFO_ERR_EN adds sticky ovf_err/udf_err flags.
module ipsum_fifo
  import ipsum_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  ipsum_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ALMOST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ROOM32 = CW'(DEPTH - 2);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       is_empty, is_full, has_room32;
  logic       pop_acc, push16_acc, push32_acc, push_acc;
  push_mode_e mode;
  psum_t      rd_data;

  assign mode       = push_mode_e'(bus.push_mod);
  assign is_empty   = (count_q == '0);
  assign is_full    = (count_q == CNT_FULL);
  assign has_room32 = (count_q <= CNT_ROOM32);

  assign pop_acc    = bus.pop_en & ~is_empty;
  assign push16_acc = bus.push_en & (mode == PUSH16) & (~is_full | pop_acc);
  assign push32_acc = bus.push_en & (mode == PUSH32) &
                      (has_room32 | ((count_q == CNT_ALMOST) & pop_acc));
  assign push_acc   = push16_acc | push32_acc;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push16_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_d + CW'(1);
    end
    if (push32_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(2);
      count_d  = count_d + CW'(2);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_d - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ipsum_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we0_i   (push_acc),
    .addr0_i (wr_ptr_q),
    .data0_i (bus.push_data[PSUM_W-1:0]),
    .we1_i   (push32_acc),
    .addr1_i (wr_ptr_q + AW'(1)),
    .data1_i (bus.push_data[GLB_W-1:PSUM_W]),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // No write-to-read bypass: a push into an empty FIFO shows up the next cycle.
  assign bus.pop_data = is_empty ? '0 : rd_data;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.ready32  = has_room32;
  assign bus.count    = count_q;

`ifdef IPSUM_FIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.push_en & ~push_acc) ovf_q <= 1'b1;
      if (bus.pop_en & is_empty)   udf_q <= 1'b1;
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;
`endif

endmodule

// File: tb/tb_ipsum_fifo.sv
// Randomized and directed bench for ipsum_fifo against a queue-based reference model.
module tb_ipsum_fifo;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ipsum_fifo_if #(.DEPTH(DEPTH)) bus ();

  ipsum_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned sz;
    sz = mq.size();
    chk({tag, ".count"},   32'(bus.count), sz);
    chk({tag, ".empty"},   32'(bus.empty), 32'(sz == 0));
    chk({tag, ".full"},    32'(bus.full), 32'(sz == DEPTH));
    chk({tag, ".ready32"}, 32'(bus.ready32), 32'(sz + 2 <= DEPTH));
    chk({tag, ".pop_data"}, 32'(bus.pop_data), (sz == 0) ? 32'h0 : 32'(mq[0]));
`ifdef IPSUM_FIFO_ERR_EN
    chk({tag, ".ovf_err"}, 32'(bus.ovf_err), 32'(m_ovf));
    chk({tag, ".udf_err"}, 32'(bus.udf_err), 32'(m_udf));
`endif
  endtask

  // Reference model: decides acceptance from occupancy alone, then updates the queue.
  task automatic model_apply(input logic en, input logic mod, input logic [31:0] d, input logic pop);
    int unsigned sz;
    bit pop_ok, push_ok;
    sz      = mq.size();
    pop_ok  = pop && (sz > 0);
    push_ok = 1'b0;
    if (en) begin
      if (!mod) push_ok = (sz < DEPTH) || pop_ok;
      else      push_ok = (sz + 2 <= DEPTH) || ((sz == DEPTH - 1) && pop_ok);
    end
    if (en && !push_ok) m_ovf = 1'b1;
    if (pop && sz == 0) m_udf = 1'b1;
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) begin
      mq.push_back(d[15:0]);
      if (mod) mq.push_back(d[31:16]);
    end
  endtask

  task automatic step(input string tag, input logic en, input logic mod,
                      input logic [31:0] d, input logic pop);
    bus.push_en   = en;
    bus.push_mod  = mod;
    bus.push_data = d;
    bus.pop_en    = pop;
    model_apply(en, mod, d, pop);
    @(posedge clk);
    #1;
    bus.push_en  = 1'b0;
    bus.push_mod = 1'b0;
    bus.pop_en   = 1'b0;
    check_outputs(tag);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1 rst = 1'b0;
    check_outputs({tag, ".release"});
  endtask

  initial begin
    bus.push_en   = 1'b0;
    bus.push_mod  = 1'b0;
    bus.push_data = '0;
    bus.pop_en    = 1'b0;

    // 1: reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs("reset");
    step("idle", 1'b0, 1'b0, 32'h0, 1'b0);

    // 2: two 16-bit pushes, two pops
    step("p16_a", 1'b1, 1'b0, 32'hFFFF_A5A5, 1'b0);
    chk("t2.head0", 32'(bus.pop_data), 32'hA5A5);
    step("p16_b", 1'b1, 1'b0, 32'h0000_1234, 1'b0);
    step("pop_a", 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2.head1", 32'(bus.pop_data), 32'h1234);
    step("pop_b", 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2.empty", 32'(bus.empty), 32'h1);

    // 3: 32-bit push, low half first
    step("p32", 1'b1, 1'b1, 32'hBEEF_1234, 1'b0);
    chk("t3.lo", 32'(bus.pop_data), 32'h1234);
    step("p32_pop0", 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3.hi", 32'(bus.pop_data), 32'hBEEF);
    step("p32_pop1", 1'b0, 1'b0, 32'h0, 1'b1);

    // 4: 32-bit push at DEPTH-1, without then with a pop
    for (int i = 0; i < DEPTH - 1; i++) step("fill", 1'b1, 1'b0, $urandom, 1'b0);
    step("p32_rej", 1'b1, 1'b1, $urandom, 1'b0);
    chk("t4.rej_count", 32'(bus.count), 32'(DEPTH - 1));
    chk("t4.rej_ready32", 32'(bus.ready32), 32'h0);
    step("p32_acc", 1'b1, 1'b1, $urandom, 1'b1);
    chk("t4.acc_count", 32'(bus.count), 32'(DEPTH));
    chk("t4.acc_full", 32'(bus.full), 32'h1);

    // 5: steady push+pop at count 8 with pointer wrap
    for (int i = 0; i < DEPTH - 8; i++) step("drain8", 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step("steady", 1'b1, 1'b0, $urandom, 1'b1);
      chk("t5.count8", 32'(bus.count), 32'd8);
    end

    // 6: underflow and overflow requests, then a mid-stream reset
    for (int i = 0; i < 8; i++) step("drain0", 1'b0, 1'b0, 32'h0, 1'b1);
    step("udf", 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("fill_full", 1'b1, 1'b0, $urandom, 1'b0);
    step("ovf16", 1'b1, 1'b0, $urandom, 1'b0);
    step("ovf32", 1'b1, 1'b1, $urandom, 1'b0);
    step("hold", 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef IPSUM_FIFO_ERR_EN
    chk("t6.udf_sticky", 32'(bus.udf_err), 32'h1);
    chk("t6.ovf_sticky", 32'(bus.ovf_err), 32'h1);
`endif
    mid_reset("rst_mid");

    // Randomized traffic with phases biased towards full or empty
    for (int i = 0; i < 3000; i++) begin
      int unsigned push_pct, pop_pct;
      push_pct = ((i / 200) % 2 == 0) ? 75 : 30;
      pop_pct  = ((i / 200) % 2 == 0) ? 30 : 75;
      step("rand",
           $urandom_range(0, 99) < push_pct,
           $urandom_range(0, 1) == 1,
           $urandom,
           $urandom_range(0, 99) < pop_pct);
      if (i == 1500) mid_reset("rst_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
